mouse_event_writer: RTL and testbench

- Sequences captured mouse events into the register file through its single write port, sharing that port with the CPU writeback path.
- Sits between the PS/2 mouse front end, the CPU writeback stage and the register file write port.
- On each `data_ready` pulse it snapshots the mouse state, writes X, Y and both buttons into their register slots, then writes the ready flag last, so software never sees a half-updated event.
- CPU writes have priority; a starvation limit guarantees forward progress.

---
 rtl/mouse_event_writer_pkg.sv | 31 +++
 rtl/mouse_event_writer_if.sv | 34 +++
 rtl/mouse_event_writer_write_port_arb.sv | 42 ++++
 rtl/mouse_event_writer.sv | 146 ++++++++++++++
 tb/tb_mouse_event_writer.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_event_writer_pkg.sv
// Shared register-index defaults and sequencer types for the mouse event writer.
// The index constants are also used by the register file and assembler tables.
package mouse_event_writer_pkg;

    localparam logic [4:0] IDX_FLAG_DEF  = 5'd21;
    localparam logic [4:0] IDX_X_DEF     = 5'd22;
    localparam logic [4:0] IDX_Y_DEF     = 5'd23;
    localparam logic [4:0] IDX_LEFT_DEF  = 5'd25;
    localparam logic [4:0] IDX_RIGHT_DEF = 5'd26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_X,
        ST_WR_Y,
        ST_WR_L,
        ST_WR_R,
        ST_WR_FLAG
    } state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        left;
        logic        right;
    } snap_t;

    function automatic logic [23:0] zext16(input logic [15:0] v);
        return {8'd0, v};
    endfunction

endpackage

// File: rtl/mouse_event_writer_if.sv
// Bundle of CPU writeback, mouse front-end and register-file write signals.
// slave is the writer's view; master is the surrounding system's view.
interface mouse_event_writer_if;

    logic [4:0]  cpu_write_index;
    logic [23:0] cpu_write_data;
    logic        cpu_write_enable;
    logic        cpu_stall;
    logic        data_ready;
    logic [15:0] mouse_x;
    logic [15:0] mouse_y;
    logic        left_click;
    logic        right_click;
    logic [4:0]  write_index;
    logic [23:0] write_data;
    logic        write_enable;
    logic        busy;
    logic [7:0]  overrun_count;

    modport slave (
        input  cpu_write_index, cpu_write_data, cpu_write_enable,
        input  data_ready, mouse_x, mouse_y, left_click, right_click,
        output cpu_stall, write_index, write_data, write_enable,
        output busy, overrun_count
    );

    modport master (
        output cpu_write_index, cpu_write_data, cpu_write_enable,
        output data_ready, mouse_x, mouse_y, left_click, right_click,
        input  cpu_stall, write_index, write_data, write_enable,
        input  busy, overrun_count
    );

endinterface

// File: rtl/mouse_event_writer_write_port_arb.sv
// Two-requester arbiter for the register-file write port: CPU wins by default,
// the sequencer is forced through after MAX_WAIT consecutive blocked cycles.
module write_port_arb #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req_i,
    input  logic seq_req_i,
    output logic grant_cpu_o,
    output logic grant_seq_o,
    output logic cpu_stall_o
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0] wait_q, wait_d;
    logic       force_grant;

    assign force_grant = seq_req_i && (wait_q == WAIT_LIMIT);
    assign cpu_stall_o = force_grant;
    assign grant_seq_o = seq_req_i && (!cpu_req_i || force_grant);
    assign grant_cpu_o = cpu_req_i && !force_grant;

    always_comb begin
        wait_d = wait_q;
        if (grant_seq_o) begin
            wait_d = 8'd0;
        end else if (cpu_req_i && seq_req_i) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/mouse_event_writer.sv
// Writes each captured mouse event into the register file (X, Y, L, R, then flag)
// through a write port shared with CPU writeback.
module mouse_event_writer
    import mouse_event_writer_pkg::*;
#(
    parameter logic [4:0]  IDX_X     = IDX_X_DEF,
    parameter logic [4:0]  IDX_Y     = IDX_Y_DEF,
    parameter logic [4:0]  IDX_LEFT  = IDX_LEFT_DEF,
    parameter logic [4:0]  IDX_RIGHT = IDX_RIGHT_DEF,
    parameter logic [4:0]  IDX_FLAG  = IDX_FLAG_DEF,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    mouse_event_writer_if.slave   bus
);

    state_e      state_q, state_d;
    snap_t       act_q, act_d;
    snap_t       pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  ovr_q, ovr_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;

    snap_t       new_ev;
    logic        seq_req, grant_cpu, grant_seq, cpu_stall;
    logic        flag_done;
    logic [4:0]  seq_idx;
    logic [23:0] seq_data;

    assign new_ev  = {bus.mouse_x, bus.mouse_y, bus.left_click, bus.right_click};
    assign seq_req = (state_q != ST_IDLE);

    write_port_arb #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .cpu_req_i  (bus.cpu_write_enable),
        .seq_req_i  (seq_req),
        .grant_cpu_o(grant_cpu),
        .grant_seq_o(grant_seq),
        .cpu_stall_o(cpu_stall)
    );

    always_comb begin
        seq_idx  = 5'd0;
        seq_data = 24'd0;
        case (state_q)
            ST_WR_X:    begin seq_idx = IDX_X;     seq_data = zext16(act_q.x);        end
            ST_WR_Y:    begin seq_idx = IDX_Y;     seq_data = zext16(act_q.y);        end
            ST_WR_L:    begin seq_idx = IDX_LEFT;  seq_data = {23'd0, act_q.left};    end
            ST_WR_R:    begin seq_idx = IDX_RIGHT; seq_data = {23'd0, act_q.right};   end
            ST_WR_FLAG: begin seq_idx = IDX_FLAG;  seq_data = 24'd1;                  end
            default:    begin seq_idx = 5'd0;      seq_data = 24'd0;                  end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        ovr_d     = ovr_q;
        flag_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_ready) begin
                    act_d   = new_ev;
                    state_d = ST_WR_X;
                end
            end
            ST_WR_X: if (grant_seq) state_d = ST_WR_Y;
            ST_WR_Y: if (grant_seq) state_d = ST_WR_L;
            ST_WR_L: if (grant_seq) state_d = ST_WR_R;
            ST_WR_R: if (grant_seq) state_d = ST_WR_FLAG;
            ST_WR_FLAG: begin
                if (grant_seq) begin
                    flag_done = 1'b1;
                    // An event arriving with the flag grant chains straight on without counting as overrun.
                    if (pend_v_q) begin
                        act_d    = pend_q;
                        state_d  = ST_WR_X;
                        pend_v_d = bus.data_ready;
                        if (bus.data_ready) pend_d = new_ev;
                    end else if (bus.data_ready) begin
                        act_d   = new_ev;
                        state_d = ST_WR_X;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.data_ready && (state_q != ST_IDLE) && !flag_done) begin
            pend_d   = new_ev;
            pend_v_d = 1'b1;
            if (pend_v_q && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
        end
    end

    always_comb begin
        wr_en_d   = grant_cpu | grant_seq;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (grant_seq) begin
            wr_idx_d  = seq_idx;
            wr_data_d = seq_data;
        end else if (grant_cpu) begin
            wr_idx_d  = bus.cpu_write_index;
            wr_data_d = bus.cpu_write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            act_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            ovr_q     <= 8'd0;
            wr_idx_q  <= 5'd0;
            wr_data_q <= 24'd0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            ovr_q     <= ovr_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.write_index   = wr_idx_q;
    assign bus.write_data    = wr_data_q;
    assign bus.write_enable  = wr_en_q;
    assign bus.busy          = seq_req;
    assign bus.overrun_count = ovr_q;
    assign bus.cpu_stall     = cpu_stall;

endmodule

// File: tb/tb_mouse_event_writer.sv
// Self-checking bench for mouse_event_writer: random events and CPU traffic checked
// against a slot-based event model (5-cycle sequences, one pending slot).
module tb_mouse_event_writer;

    localparam int MW    = 3;
    localparam int WORST = 5 * (MW + 1) + 1;

    typedef struct { int cyc; logic [4:0] idx; logic [23:0] data; } wr_t;
    typedef struct { int cyc; logic [15:0] x; logic [15:0] y; logic l; logic r; } ev_t;
    typedef struct { logic [4:0] idx; logic [23:0] data; } cw_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mouse_event_writer_if bus();

    mouse_event_writer #(
        .IDX_X(5'd22), .IDX_Y(5'd23), .IDX_LEFT(5'd25), .IDX_RIGHT(5'd26),
        .IDX_FLAG(5'd21), .MAX_WAIT(MW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    ev_t  pulses_q[$];
    int   exp_ovr;
    cw_t  cpu_todo[$];
    cw_t  cpu_ref[$];
    bit   cpu_on   = 1'b0;
    int   cpu_rate = 100;
    bit   cpu_acc  = 1'b0;
    int   stall_cyc[$];

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic step();
        wr_t w;
        bit  prev_req, want;
        @(negedge clk);
        cyc++;
        if (bus.write_enable) begin
            w.cyc = cyc; w.idx = bus.write_index; w.data = bus.write_data;
            got_q.push_back(w);
        end
        if (bus.cpu_stall) stall_cyc.push_back(cyc);
        bus.data_ready = 1'b0;
        prev_req = bus.cpu_write_enable;
        if (prev_req && cpu_acc && cpu_todo.size() > 0) cpu_todo.delete(0);
        want = (prev_req && !cpu_acc) || (cpu_on && ($urandom_range(0, 99) < cpu_rate));
        bus.cpu_write_enable = 1'b0;
        if (want && cpu_todo.size() > 0) begin
            bus.cpu_write_enable = 1'b1;
            bus.cpu_write_index  = cpu_todo[0].idx;
            bus.cpu_write_data   = cpu_todo[0].data;
        end
        cpu_acc = bus.cpu_write_enable && !bus.cpu_stall;
    endtask

    task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic l, input logic r);
        ev_t e;
        bus.data_ready  = 1'b1;
        bus.mouse_x     = x;
        bus.mouse_y     = y;
        bus.left_click  = l;
        bus.right_click = r;
        e.cyc = cyc; e.x = x; e.y = y; e.l = l; e.r = r;
        pulses_q.push_back(e);
    endtask

    task automatic rand_pulse();
        pulse(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic fill_cpu(input int n);
        cw_t c;
        cpu_todo.delete();
        cpu_ref.delete();
        for (int i = 0; i < n; i++) begin
            c.idx  = 5'($urandom_range(0, 31));
            c.data = 24'($urandom) | 24'h800000;
            cpu_todo.push_back(c);
            cpu_ref.push_back(c);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        pulses_q.delete();
        stall_cyc.delete();
    endtask

    task automatic apply_reset();
        cpu_on = 1'b0;
        cpu_acc = 1'b0;
        bus.cpu_write_enable = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic emit(input ev_t e, input int s);
        wr_t w;
        w.cyc = s + 2; w.idx = 5'd22; w.data = {8'd0, e.x};    exp_q.push_back(w);
        w.cyc = s + 3; w.idx = 5'd23; w.data = {8'd0, e.y};    exp_q.push_back(w);
        w.cyc = s + 4; w.idx = 5'd25; w.data = {23'd0, e.l};   exp_q.push_back(w);
        w.cyc = s + 5; w.idx = 5'd26; w.data = {23'd0, e.r};   exp_q.push_back(w);
        w.cyc = s + 6; w.idx = 5'd21; w.data = 24'd1;          exp_q.push_back(w);
    endtask

    // Uncontended model: an event started at s owns the port until its flag grant at s+5;
    // a single pending slot holds the newest event arriving meanwhile.
    task automatic model_build();
        int  free_at;
        bit  pend;
        ev_t pe;
        free_at = -1000;
        pend    = 1'b0;
        exp_q.delete();
        exp_ovr = 0;
        foreach (pulses_q[i]) begin
            if (pend && free_at <= pulses_q[i].cyc) begin
                emit(pe, free_at);
                free_at += 5;
                pend = 1'b0;
            end
            if (pulses_q[i].cyc >= free_at) begin
                emit(pulses_q[i], pulses_q[i].cyc);
                free_at = pulses_q[i].cyc + 5;
            end else begin
                if (pend && exp_ovr < 255) exp_ovr++;
                pe   = pulses_q[i];
                pend = 1'b1;
            end
        end
        if (pend) emit(pe, free_at);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        total++; if (bus.write_enable !== 1'b0)  begin bad++; $display("FAIL reset_we: got %0b want 0", bus.write_enable); end
        total++; if (bus.write_index !== 5'd0)   begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.write_index); end
        total++; if (bus.write_data !== 24'd0)   begin bad++; $display("FAIL reset_data: got %0h want 0", bus.write_data); end
        total++; if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++; if (bus.overrun_count !== 8'd0) begin bad++; $display("FAIL reset_ovr: got %0d want 0", bus.overrun_count); end
        total++; if (bus.cpu_stall !== 1'b0)     begin bad++; $display("FAIL reset_stall: got %0b want 0", bus.cpu_stall); end
        reset = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_single();
        int  c;
        logic want_busy;
        apply_reset();
        pulse(16'h1234, 16'h00FF, 1'b1, 1'b0);
        c = cyc;
        for (int i = 0; i < 9; i++) begin
            step();
            want_busy = (cyc >= c + 1) && (cyc <= c + 5);
            total++;
            if (bus.busy !== want_busy) begin
                bad++; $display("FAIL single_busy@%0d: got %0b want %0b", cyc - c, bus.busy, want_busy);
            end
        end
        model_build();
        total++;
        if (got_q.size() != 5) begin bad++; $display("FAIL single_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL single_wr%0d: got c%0d i%0d d%0h want c%0d i%0d d%0h", i,
                    got_q[i].cyc - c, got_q[i].idx, got_q[i].data, exp_q[i].cyc - c, exp_q[i].idx, exp_q[i].data);
            end
        end
        total++;
        if (got_q.size() > 0 && (got_q[0].idx !== 5'd22 || got_q[0].data !== 24'h001234)) begin
            bad++; $display("FAIL single_x: got i%0d d%0h want i22 d1234", got_q[0].idx, got_q[0].data);
        end
        total++;
        if (bus.overrun_count !== 8'd0) begin bad++; $display("FAIL single_ovr: got %0d want 0", bus.overrun_count); end
    endtask

    task automatic test_event_stream(input string name, input int npulse, input int maxgap);
        int gap;
        apply_reset();
        for (int i = 0; i < npulse; i++) begin
            gap = $urandom_range(1, maxgap);
            for (int g = 0; g < gap; g++) step();
            rand_pulse();
        end
        for (int i = 0; i < 20; i++) step();
        model_build();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL %s_wr%0d: got c%0d i%0d d%0h want c%0d i%0d d%0h", name, i,
                    got_q[i].cyc, got_q[i].idx, got_q[i].data, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
            end
        end
        total++;
        if (bus.overrun_count !== 8'(exp_ovr)) begin
            bad++; $display("FAIL %s_ovr: got %0d want %0d", name, bus.overrun_count, exp_ovr);
        end
    endtask

    task automatic test_three_pulses();
        apply_reset();
        rand_pulse(); step();
        rand_pulse(); step(); step();
        rand_pulse();
        for (int i = 0; i < 20; i++) step();
        model_build();
        total++;
        if (bus.overrun_count !== 8'd1) begin bad++; $display("FAIL three_ovr: got %0d want 1", bus.overrun_count); end
        total++;
        if (got_q.size() != 10) begin bad++; $display("FAIL three_count: got %0d want 10", got_q.size()); end
        total++;
        if (got_q.size() >= 6 && got_q[5].data !== {8'd0, pulses_q[2].x}) begin
            bad++; $display("FAIL three_ev3x: got %0h want %0h", got_q[5].data, pulses_q[2].x);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL three_wr%0d: got c%0d i%0d d%0h want c%0d i%0d d%0h", i,
                    got_q[i].cyc, got_q[i].idx, got_q[i].data, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
            end
        end
    endtask

    task automatic test_flag_chain();
        int c;
        apply_reset();
        rand_pulse();
        c = cyc;
        for (int i = 0; i < 5; i++) step();
        rand_pulse();
        for (int i = 0; i < 15; i++) step();
        model_build();
        total++;
        if (bus.overrun_count !== 8'd0) begin bad++; $display("FAIL chain_ovr: got %0d want 0", bus.overrun_count); end
        total++;
        if (got_q.size() != 10) begin
            bad++; $display("FAIL chain_count: got %0d want 10", got_q.size());
        end else if (got_q[5].cyc != c + 7 || got_q[4].cyc != c + 6) begin
            bad++; $display("FAIL chain_start: got flag@%0d x2@%0d want 6 7", got_q[4].cyc - c, got_q[5].cyc - c);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL chain_wr%0d: got c%0d i%0d d%0h want c%0d i%0d d%0h", i,
                    got_q[i].cyc, got_q[i].idx, got_q[i].data, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rand_pulse();
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if (bus.write_enable !== 1'b0 || bus.write_index !== 5'd0 || bus.write_data !== 24'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midreset_out: got we%0b i%0d d%0h busy%0b want all 0",
                bus.write_enable, bus.write_index, bus.write_data, bus.busy);
        end
        step();
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) step();
        total++;
        if (got_q.size() != 0) begin
            bad++; $display("FAIL midreset_nowrite: got %0d writes (first idx %0d) want 0", got_q.size(), got_q[0].idx);
        end
        clear_logs();
        rand_pulse();
        for (int i = 0; i < 10; i++) step();
        model_build();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL midreset_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL midreset_wr%0d: got i%0d d%0h want i%0d d%0h", i,
                    got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
    endtask

    task automatic test_cpu_contention();
        int c, k, ci, issued;
        apply_reset();
        fill_cpu(80);
        cpu_on = 1'b1;
        cpu_rate = 100;
        for (int i = 0; i < 5; i++) step();
        rand_pulse();
        c = cyc;
        for (int i = 0; i < 30; i++) step();
        cpu_on = 1'b0;
        for (int i = 0; i < 3; i++) step();
        model_build();
        issued = cpu_ref.size() - cpu_todo.size();
        k = 0; ci = 0;
        foreach (got_q[i]) begin
            total++;
            if (k < 5 && got_q[i].cyc == c + 5 + 4 * k) begin
                if (got_q[i].idx !== exp_q[k].idx || got_q[i].data !== exp_q[k].data) begin
                    bad++; $display("FAIL cont_seq%0d: got i%0d d%0h want i%0d d%0h", k,
                        got_q[i].idx, got_q[i].data, exp_q[k].idx, exp_q[k].data);
                end
                k++;
            end else begin
                if (ci >= cpu_ref.size() || got_q[i].idx !== cpu_ref[ci].idx || got_q[i].data !== cpu_ref[ci].data) begin
                    bad++; $display("FAIL cont_cpu%0d: got i%0d d%0h at c%0d", ci, got_q[i].idx, got_q[i].data, got_q[i].cyc - c);
                end
                ci++;
            end
        end
        total++;
        if (k != 5 || ci != issued) begin
            bad++; $display("FAIL cont_counts: got seq %0d cpu %0d want seq 5 cpu %0d", k, ci, issued);
        end
        total++;
        if (stall_cyc.size() != 5) begin
            bad++; $display("FAIL cont_stall_count: got %0d want 5", stall_cyc.size());
        end
        for (int i = 0; i < stall_cyc.size() && i < 5; i++) begin
            total++;
            if (stall_cyc[i] != c + 4 + 4 * i) begin
                bad++; $display("FAIL cont_stall%0d: got c%0d want c%0d", i, stall_cyc[i] - c, 4 + 4 * i);
            end
        end
    endtask

    task automatic test_cpu_random();
        wr_t seq_q[$];
        wr_t cpu_got[$];
        int  nev, fi;
        apply_reset();
        fill_cpu(200);
        cpu_on = 1'b1;
        cpu_rate = 60;
        nev = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i % 40 == 5 && nev < 6) begin rand_pulse(); nev++; end
        end
        cpu_on = 1'b0;
        for (int i = 0; i < 600 && (cpu_todo.size() > 0 || bus.busy); i++) step();
        step(); step();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL crand_timeout: busy %0b want 0", bus.busy); end
        model_build();
        foreach (got_q[i]) begin
            if (got_q[i].data[23]) cpu_got.push_back(got_q[i]);
            else seq_q.push_back(got_q[i]);
        end
        total++;
        if (cpu_got.size() != cpu_ref.size() - cpu_todo.size()) begin
            bad++; $display("FAIL crand_cpu_count: got %0d want %0d", cpu_got.size(), cpu_ref.size() - cpu_todo.size());
        end
        for (int i = 0; i < cpu_got.size() && i < cpu_ref.size(); i++) begin
            total++;
            if (cpu_got[i].idx !== cpu_ref[i].idx || cpu_got[i].data !== cpu_ref[i].data) begin
                bad++; $display("FAIL crand_cpu%0d: got i%0d d%0h want i%0d d%0h", i,
                    cpu_got[i].idx, cpu_got[i].data, cpu_ref[i].idx, cpu_ref[i].data);
            end
        end
        total++;
        if (seq_q.size() != exp_q.size()) begin
            bad++; $display("FAIL crand_seq_count: got %0d want %0d", seq_q.size(), exp_q.size());
        end
        for (int i = 0; i < seq_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (seq_q[i].idx !== exp_q[i].idx || seq_q[i].data !== exp_q[i].data) begin
                bad++; $display("FAIL crand_seq%0d: got i%0d d%0h want i%0d d%0h", i,
                    seq_q[i].idx, seq_q[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        fi = 0;
        foreach (seq_q[i]) begin
            if (seq_q[i].idx == 5'd21 && fi < pulses_q.size()) begin
                total++;
                if (seq_q[i].cyc - pulses_q[fi].cyc > WORST) begin
                    bad++; $display("FAIL crand_latency%0d: got %0d want <= %0d", fi, seq_q[i].cyc - pulses_q[fi].cyc, WORST);
                end
                fi++;
            end
        end
        total++;
        if (bus.overrun_count !== 8'd0) begin bad++; $display("FAIL crand_ovr: got %0d want 0", bus.overrun_count); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 520; i++) begin
            step();
            rand_pulse();
        end
        for (int i = 0; i < 20; i++) step();
        model_build();
        total++;
        if (bus.overrun_count !== 8'd255) begin bad++; $display("FAIL sat_ovr: got %0d want 255", bus.overrun_count); end
        total++;
        if (bus.overrun_count !== 8'(exp_ovr)) begin bad++; $display("FAIL sat_model: got %0d want %0d", bus.overrun_count, exp_ovr); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL sat_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] != exp_q[i]) begin
                bad++; $display("FAIL sat_wr%0d: got c%0d i%0d d%0h want c%0d i%0d d%0h", i,
                    got_q[i].cyc, got_q[i].idx, got_q[i].data, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
            end
        end
    endtask

    initial begin
        reset                = 1'b1;
        bus.cpu_write_index  = 5'd0;
        bus.cpu_write_data   = 24'd0;
        bus.cpu_write_enable = 1'b0;
        bus.data_ready       = 1'b0;
        bus.mouse_x          = 16'd0;
        bus.mouse_y          = 16'd0;
        bus.left_click       = 1'b0;
        bus.right_click      = 1'b0;
        test_reset();
        test_single();
        test_flag_chain();
        test_three_pulses();
        test_event_stream("rand_events", 40, 8);
        test_reset_mid();
        test_cpu_contention();
        test_cpu_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
